// File: rtl/mux_nto1_scan.sv
// ---------------------------------------------------------------------------
// mux_nto1_scan
//   N-channel, WIDTH-bit multiplexer with registered outputs, active-low
//   enable, a manual-select mode and a round-robin auto-scan mode with a
//   programmable dwell time per channel.
//
// Ports
//   CLK   in   1               system clock, rising edge
//   RST   in   1               synchronous, active-high reset
//   E     in   1               enable, active-low (E=1 disables the block)
//   MODE  in   1               0 = manual select via S, 1 = auto-scan
//   S     in   SEL_W           manual channel select
//   D     in   CHANNELS*WIDTH  flattened data, channel k = D[k*WIDTH +: WIDTH]
//   Y     out  WIDTH           registered selected data
//   V     out  1               Y valid
//   CH    out  SEL_W           channel index currently presented on Y
//
// Build option
//   MUXSCAN_HOLD_EN  when defined, the disabled state holds Y/CH and freezes
//                    the scan pointer and dwell counter so a re-enabled scan
//                    resumes where it stopped. Undefined: disabled state
//                    drives Y=0 and the scan restarts at channel 0.
// ---------------------------------------------------------------------------
module mux_nto1_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 2,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      E,
  input  logic                      MODE,
  input  logic [SEL_W-1:0]          S,
  input  logic [CHANNELS*WIDTH-1:0] D,
  output logic [WIDTH-1:0]          Y,
  output logic                      V,
  output logic [SEL_W-1:0]          CH
);

  localparam int CNT_W = $clog2(DWELL + 1);

  typedef enum logic [1:0] {
    ST_DIS  = 2'd0,
    ST_MAN  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t state_reg, state_next;

  logic [SEL_W-1:0] ptr_reg, ptr_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [SEL_W-1:0] scan_ptr;
  logic [CNT_W-1:0] scan_cnt;

  logic [WIDTH-1:0] y_reg, y_next;
  logic             v_reg, v_next;
  logic [SEL_W-1:0] ch_reg, ch_next;

  logic [SEL_W-1:0] sel_idx;
  logic [WIDTH-1:0] sel_data;
  logic             sel_hit;

  // Unflattened view of the channel inputs.
  logic [WIDTH-1:0] chan [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign chan[gi] = D[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= ST_DIS;
    end else begin
      state_reg <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next state is a pure decode of E and MODE every cycle
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = ST_DIS;
    if (!E) begin
      state_next = MODE ? ST_SCAN : ST_MAN;
    end
  end

  // -------------------------------------------------------------------------
  // Scan step: the pointer/counter values that a SCAN edge would load.
  // A zero dwell counter outside SCAN marks a fresh start (after reset, MAN,
  // or a clearing DIS); a non-zero one can only survive a holding DIS, in
  // which case the scan continues from the frozen position.
  // -------------------------------------------------------------------------
  always_comb begin
    scan_ptr = ptr_reg;
    scan_cnt = cnt_reg;
    if ((state_reg != ST_SCAN) && (cnt_reg == '0)) begin
      scan_ptr = '0;
      scan_cnt = CNT_W'(1);
    end else if (cnt_reg == CNT_W'(DWELL)) begin
      scan_cnt = CNT_W'(1);
      scan_ptr = (ptr_reg == SEL_W'(CHANNELS - 1)) ? '0 : ptr_reg + 1'b1;
    end else begin
      scan_cnt = cnt_reg + 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Channel select. Indices beyond CHANNELS-1 (only reachable when CHANNELS
  // is not a power of two) report no hit, giving Y=0 / V=0 in MAN.
  // -------------------------------------------------------------------------
  assign sel_idx = (state_next == ST_SCAN) ? scan_ptr : S;

  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (sel_idx == SEL_W'(k)) begin
        sel_data = chan[k];
        sel_hit  = 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: output decode (next values of the registered outputs)
  // -------------------------------------------------------------------------
  always_comb begin
    y_next   = y_reg;
    v_next   = v_reg;
    ch_next  = ch_reg;
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    case (state_next)
      ST_MAN: begin
        y_next   = sel_hit ? sel_data : '0;
        v_next   = sel_hit;
        ch_next  = S;
        // Forget the scan position so a later SCAN starts at channel 0.
        ptr_next = '0;
        cnt_next = '0;
      end
      ST_SCAN: begin
        y_next   = sel_data;
        v_next   = 1'b1;
        ch_next  = scan_ptr;
        ptr_next = scan_ptr;
        cnt_next = scan_cnt;
      end
      default: begin
`ifdef MUXSCAN_HOLD_EN
        v_next   = 1'b0;
`else
        y_next   = '0;
        v_next   = 1'b0;
        ptr_next = '0;
        cnt_next = '0;
`endif
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      y_reg   <= '0;
      v_reg   <= 1'b0;
      ch_reg  <= '0;
      ptr_reg <= '0;
      cnt_reg <= '0;
    end else begin
      y_reg   <= y_next;
      v_reg   <= v_next;
      ch_reg  <= ch_next;
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
    end
  end

  assign Y  = y_reg;
  assign V  = v_reg;
  assign CH = ch_reg;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// ---------------------------------------------------------------------------
// tb_mux_nto1_scan
//   Directed-vector bench for mux_nto1_scan (WIDTH=4, CHANNELS=4, DWELL=2).
//   Stimulus pushes the hand-computed response of each edge into a queue;
//   a separate monitor pops and compares after every rising edge.
// ---------------------------------------------------------------------------
module tb_mux_nto1_scan;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int DWELL    = 2;
  localparam int SEL_W    = 2;

`ifdef MUXSCAN_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  // ch3..ch0 = C,3,5,A ; D1 changes ch3 to 7
  localparam logic [15:0] D0 = 16'hC35A;
  localparam logic [15:0] D1 = 16'h735A;

  logic                      CLK = 1'b0;
  logic                      RST;
  logic                      E;
  logic                      MODE;
  logic [SEL_W-1:0]          S;
  logic [CHANNELS*WIDTH-1:0] D;
  logic [WIDTH-1:0]          Y;
  logic                      V;
  logic [SEL_W-1:0]          CH;

  mux_nto1_scan #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHANNELS),
    .DWELL    (DWELL)
  ) dut (
    .CLK  (CLK),
    .RST  (RST),
    .E    (E),
    .MODE (MODE),
    .S    (S),
    .D    (D),
    .Y    (Y),
    .V    (V),
    .CH   (CH)
  );

  always #5 CLK = ~CLK;

  logic [6:0] exp_q [$];   // {Y, V, CH}
  int         id_q  [$];
  int         checks = 0;
  int         errors = 0;
  int         txn    = 0;

  // Drive one cycle of inputs and queue the response expected after the
  // following rising edge.
  task automatic step(input logic rst, input logic e, input logic mode,
                      input logic [1:0] s, input logic [15:0] d,
                      input logic [3:0] ey, input logic ev, input logic [1:0] ech);
    @(negedge CLK);
    RST  = rst;
    E    = e;
    MODE = mode;
    S    = s;
    D    = d;
    exp_q.push_back({ey, ev, ech});
    id_q.push_back(txn);
    txn++;
  endtask

  // Monitor: every rising edge presents a new registered output word.
  initial begin
    forever begin
      logic [6:0] ex;
      int         id;
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        ex = exp_q.pop_front();
        id = id_q.pop_front();
        checks++;
        if ({Y, V, CH} !== ex) begin
          errors++;
          $display("FAIL txn %0d: got Y=%h V=%b CH=%0d, want Y=%h V=%b CH=%0d",
                   id, Y, V, CH, ex[6:3], ex[2], ex[1:0]);
        end else begin
          $display("txn %0d: Y=%h V=%b CH=%0d", id, Y, V, CH);
        end
      end
    end
  end

  // Expected per-edge scan sequence entering SCAN from DIS.
  logic [1:0] scan_ch [10] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0};
  logic [3:0] scan_y  [10] = '{4'hA, 4'hA, 4'h5, 4'h5, 4'h3, 4'h3, 4'hC, 4'hC, 4'hA, 4'hA};

  initial begin
    RST  = 1'b1;
    E    = 1'b0;
    MODE = 1'b1;
    S    = 2'd0;
    D    = D0;

    // Reset for two edges
    step(1'b1, 1'b0, 1'b1, 2'd0, D0, 4'h0, 1'b0, 2'd0);
    step(1'b1, 1'b0, 1'b1, 2'd0, D0, 4'h0, 1'b0, 2'd0);

    // Manual select
    step(1'b0, 1'b0, 1'b0, 2'd2, D0, 4'h3, 1'b1, 2'd2);
    step(1'b0, 1'b0, 1'b0, 2'd0, D0, 4'hA, 1'b1, 2'd0);

    // Disable for one edge (CH holds)
    step(1'b0, 1'b1, 1'b0, 2'd0, D0, HOLD ? 4'hA : 4'h0, 1'b0, 2'd0);

    // Scan from DIS
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'd0, D0, scan_y[i], 1'b1, scan_ch[i]);
    end
    step(1'b0, 1'b0, 1'b1, 2'd0, D0, 4'h5, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b1, 2'd0, D0, 4'h5, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b1, 2'd0, D0, 4'h3, 1'b1, 2'd2);

    // Mid-scan switch to manual S=1, then back to scan (restarts at 0)
    step(1'b0, 1'b0, 1'b0, 2'd1, D0, 4'h5, 1'b1, 2'd1);
    step(1'b0, 1'b0, 1'b1, 2'd1, D0, 4'hA, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, D0, 4'hA, 1'b1, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, D0, 4'h5, 1'b1, 2'd1);

    // Disable at CH=1 (first dwell cycle) for three edges, then re-enable
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 2'd1, D0, HOLD ? 4'h5 : 4'h0, 1'b0, 2'd1);
    end
    step(1'b0, 1'b0, 1'b1, 2'd1, D0, HOLD ? 4'h5 : 4'hA, 1'b1, HOLD ? 2'd1 : 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd1, D0, HOLD ? 4'h3 : 4'hA, 1'b1, HOLD ? 2'd2 : 2'd0);

    // Manual S=3, live data change on ch3
    step(1'b0, 1'b0, 1'b0, 2'd3, D0, 4'hC, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b0, 2'd3, D0, 4'hC, 1'b1, 2'd3);
    step(1'b0, 1'b0, 1'b0, 2'd3, D1, 4'h7, 1'b1, 2'd3);

    // Reset mid-sequence, then scan restarts at channel 0
    step(1'b1, 1'b0, 1'b0, 2'd3, D1, 4'h0, 1'b0, 2'd0);
    step(1'b0, 1'b0, 1'b1, 2'd0, D1, 4'hA, 1'b1, 2'd0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
      #2;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending responses, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
